// File: rtl/multi_chan_delay_line.sv
// Multi-channel programmable sample delay line.
// Per-channel taps are double-buffered: writes go to a shadow copy, and the shadow
// copy becomes active together for all channels on a sample strobe. Each output is
// forced to 0 until its channel holds enough samples for its tap.
// Optional feature macro: DLY_INVERT_EN adds a per-channel saturating negation
// at the output register.
module multi_chan_delay_line #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned TAP_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic                   din_valid,
    input  logic                   bypass,
    input  logic                   tap_wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] tap_wr_ch,
    input  logic [TAP_W-1:0]       tap_wr_data,
    input  logic                   tap_commit,
`ifdef DLY_INVERT_EN
    input  logic [NCH-1:0]         invert,
`endif
    output logic [NCH*WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic [NCH-1:0]         primed,
    output logic                   commit_busy
);

    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned FILL_W = TAP_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [TAP_W-1:0]     tap_sh_q  [NCH];
    logic [TAP_W-1:0]     tap_sh_d  [NCH];
    logic [TAP_W-1:0]     tap_act_q [NCH];
    logic [TAP_W-1:0]     tap_act_d [NCH];
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [NCH*WIDTH-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [NCH-1:0]       primed_q, primed_d;
    logic                 commit_busy_q, commit_busy_d;
    logic [WIDTH-1:0]     line_q [NCH][DEPTH-1];
    logic [WIDTH-1:0]     line_d [NCH][DEPTH-1];
    logic                 do_copy;
    logic [WIDTH-1:0]     sel;

`ifdef DLY_INVERT_EN
    // Two's-complement negation with the most negative value clamped to the most positive
    function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};
        if (x == most_neg) return ~most_neg;
        return WIDTH'(~x + WIDTH'(1));
    endfunction
`endif

    // Shadow tap writes and commit FSM; a copy uses this cycle's shadow including any write
    always_comb begin
        tap_sh_d  = tap_sh_q;
        tap_act_d = tap_act_q;
        state_d   = state_q;
        do_copy   = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (tap_wr && (tap_wr_ch == CH_W'(ch))) tap_sh_d[ch] = tap_wr_data;
        end
        case (state_q)
            ST_IDLE: begin
                if (tap_commit) begin
                    if (din_valid) do_copy = 1'b1;
                    else           state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (din_valid) begin
                    do_copy = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_copy) tap_act_d = tap_sh_d;
        commit_busy_d = (state_d == ST_PEND);
    end

    // Saturating fill count and per-channel primed flags against the taps in force after this edge
    always_comb begin
        fill_d = fill_q;
        if (din_valid && (fill_q < FILL_W'(DEPTH))) fill_d = FILL_W'(fill_q + FILL_W'(1));
        for (int ch = 0; ch < NCH; ch++) begin
            primed_d[ch] = (fill_d > FILL_W'(tap_act_d[ch]));
        end
    end

    // Delay-line shift on each strobe
    always_comb begin
        line_d = line_q;
        if (din_valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
                line_d[ch][0] = din[ch*WIDTH +: WIDTH];
                for (int k = 1; k < DEPTH - 1; k++) begin
                    line_d[ch][k] = line_q[ch][k-1];
                end
            end
        end
    end

    // Output tap select, masking, bypass and optional negation
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = din_valid;
        sel          = '0;
        if (din_valid) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (bypass || (tap_act_d[ch] == '0)) begin
                    sel = din[ch*WIDTH +: WIDTH];
                end else begin
                    sel = line_q[ch][TAP_W'(tap_act_d[ch] - TAP_W'(1))];
                end
                if (!bypass && !primed_d[ch]) sel = '0;
`ifdef DLY_INVERT_EN
                if (invert[ch]) sel = neg_sat(sel);
`endif
                dout_d[ch*WIDTH +: WIDTH] = sel;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fill_q        <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            primed_q      <= '0;
            commit_busy_q <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                tap_sh_q[ch]  <= '0;
                tap_act_q[ch] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            primed_q      <= primed_d;
            commit_busy_q <= commit_busy_d;
            tap_sh_q      <= tap_sh_d;
            tap_act_q     <= tap_act_d;
        end
    end

    // Sample storage is left unreset so it can map onto shift-register primitives
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign primed      = primed_q;
    assign commit_busy = commit_busy_q;

endmodule

// File: tb/tb_multi_chan_delay_line.sv
// Directed bench for multi_chan_delay_line: a cycle table plus hand-written sequences
// for strobe spacing, mid-run reset and fill saturation.
module tb_multi_chan_delay_line;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        din_valid, bypass, tap_wr, tap_commit;
    logic [1:0]  tap_wr_ch;
    logic [4:0]  tap_wr_data;
    logic [3:0]  invert;
    logic [63:0] dout;
    logic        dout_valid, commit_busy;
    logic [3:0]  primed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_chan_delay_line dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .bypass      (bypass),
        .tap_wr      (tap_wr),
        .tap_wr_ch   (tap_wr_ch),
        .tap_wr_data (tap_wr_data),
        .tap_commit  (tap_commit),
`ifdef DLY_INVERT_EN
        .invert      (invert),
`endif
        .dout        (dout),
        .dout_valid  (dout_valid),
        .primed      (primed),
        .commit_busy (commit_busy)
    );

    typedef struct {
        logic        dv, byp, wr;
        logic [1:0]  ch;
        logic [4:0]  wd;
        logic        cm;
        logic [15:0] d0;
        logic        ev;
        logic [15:0] e0, e1;
        logic [3:0]  ep;
        logic        eb;
    } vec_t;

    vec_t tbl [23];

    task automatic row(input int i, input logic dv, input logic byp, input logic wr,
                       input logic [1:0] ch, input logic [4:0] wd, input logic cm,
                       input logic [15:0] d0, input logic ev, input logic [15:0] e0,
                       input logic [15:0] e1, input logic [3:0] ep, input logic eb);
        tbl[i].dv = dv; tbl[i].byp = byp; tbl[i].wr = wr; tbl[i].ch = ch;
        tbl[i].wd = wd; tbl[i].cm = cm;   tbl[i].d0 = d0; tbl[i].ev = ev;
        tbl[i].e0 = e0; tbl[i].e1 = e1;   tbl[i].ep = ep; tbl[i].eb = eb;
    endtask

    // Channel k carries d0 with k in the top nibble
    task automatic drive(input logic dv, input logic byp, input logic wr, input logic [1:0] ch,
                         input logic [4:0] wd, input logic cm, input logic [15:0] d0);
        din_valid   = dv;
        bypass      = byp;
        tap_wr      = wr;
        tap_wr_ch   = ch;
        tap_wr_data = wd;
        tap_commit  = cm;
        din = {d0 | 16'h3000, d0 | 16'h2000, d0 | 16'h1000, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [15:0] t2_exp [3];

    initial begin
        invert = 4'b0000;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);

        //      i   dv byp wr ch wd cm  d0       ev e0       e1       ep       eb
        row( 0, 0, 0, 1, 0,  3, 1, 16'h0000, 0, 16'h0000, 16'h0000, 4'b0000, 1);
        row( 1, 1, 0, 0, 0,  0, 0, 16'h0001, 1, 16'h0000, 16'h1001, 4'b1110, 0);
        row( 2, 1, 0, 0, 0,  0, 0, 16'h0002, 1, 16'h0000, 16'h1002, 4'b1110, 0);
        row( 3, 1, 0, 0, 0,  0, 0, 16'h0003, 1, 16'h0000, 16'h1003, 4'b1110, 0);
        row( 4, 1, 0, 0, 0,  0, 0, 16'h0004, 1, 16'h0001, 16'h1004, 4'b1111, 0);
        row( 5, 0, 0, 0, 0,  0, 0, 16'h00AA, 0, 16'h0001, 16'h1004, 4'b1111, 0);
        row( 6, 1, 0, 0, 0,  0, 0, 16'h0005, 1, 16'h0002, 16'h1005, 4'b1111, 0);
        row( 7, 0, 0, 1, 1,  5, 1, 16'h00AA, 0, 16'h0002, 16'h1005, 4'b1111, 1);
        row( 8, 0, 0, 0, 0,  0, 0, 16'h00AA, 0, 16'h0002, 16'h1005, 4'b1111, 1);
        row( 9, 0, 0, 0, 0,  0, 0, 16'h00AA, 0, 16'h0002, 16'h1005, 4'b1111, 1);
        row(10, 0, 0, 0, 0,  0, 0, 16'h00AA, 0, 16'h0002, 16'h1005, 4'b1111, 1);
        row(11, 1, 0, 0, 0,  0, 0, 16'h0006, 1, 16'h0003, 16'h1001, 4'b1111, 0);
        row(12, 1, 0, 0, 0,  0, 0, 16'h0007, 1, 16'h0004, 16'h1002, 4'b1111, 0);
        row(13, 1, 0, 1, 0, 10, 1, 16'h0008, 1, 16'h0000, 16'h1003, 4'b1110, 0);
        row(14, 1, 0, 0, 0,  0, 0, 16'h0009, 1, 16'h0000, 16'h1004, 4'b1110, 0);
        row(15, 1, 0, 0, 0,  0, 0, 16'h000A, 1, 16'h0000, 16'h1005, 4'b1110, 0);
        row(16, 1, 0, 0, 0,  0, 0, 16'h000B, 1, 16'h0001, 16'h1006, 4'b1111, 0);
        row(17, 1, 1, 0, 0,  0, 0, 16'h8000, 1, 16'h8000, 16'h9000, 4'b1111, 0);
        row(18, 1, 0, 0, 0,  0, 0, 16'h000D, 1, 16'h0003, 16'h1008, 4'b1111, 0);
        row(19, 0, 0, 0, 0,  0, 1, 16'h00AA, 0, 16'h0003, 16'h1008, 4'b1111, 1);
        row(20, 0, 0, 0, 0,  0, 1, 16'h00AA, 0, 16'h0003, 16'h1008, 4'b1111, 1);
        row(21, 0, 0, 1, 0,  0, 0, 16'h00AA, 0, 16'h0003, 16'h1008, 4'b1111, 1);
        row(22, 1, 0, 0, 0,  0, 0, 16'h000E, 1, 16'h000E, 16'h1009, 4'b1111, 0);

        // Reset state
        tick();
        tick();
        chk("rst_dout0", dout[15:0], 16'h0000);
        chk("rst_dout3", dout[63:48], 16'h0000);
        chk("rst_valid", 16'(dout_valid), 16'h0000);
        chk("rst_primed", 16'(primed), 16'h0000);
        chk("rst_busy", 16'(commit_busy), 16'h0000);
        #2 rst = 1'b0;

        // Cycle table: fill-up, idle hold, deferred commit, tap increase, bypass, repeat commit
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].dv, tbl[i].byp, tbl[i].wr, tbl[i].ch, tbl[i].wd, tbl[i].cm, tbl[i].d0);
            tick();
            chk($sformatf("row%0d_valid", i), 16'(dout_valid), 16'(tbl[i].ev));
            chk($sformatf("row%0d_dout0", i), dout[15:0], tbl[i].e0);
            chk($sformatf("row%0d_dout1", i), dout[31:16], tbl[i].e1);
            chk($sformatf("row%0d_primed", i), 16'(primed), 16'(tbl[i].ep));
            chk($sformatf("row%0d_busy", i), 16'(commit_busy), 16'(tbl[i].eb));
        end

        // Strobe every third clock; ch0 tap 2 committed on the first strobe
        t2_exp[0] = 16'h000D;
        t2_exp[1] = 16'h000E;
        t2_exp[2] = 16'h0064;
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 1'b0, (s == 0), 2'd0, 5'd2, (s == 0), 16'(100 + s));
            tick();
            chk($sformatf("sp%0d_valid", s), 16'(dout_valid), 16'h0001);
            chk($sformatf("sp%0d_dout0", s), dout[15:0], t2_exp[s]);
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h00AA);
                tick();
                chk($sformatf("sp%0d_gap%0d_valid", s, g), 16'(dout_valid), 16'h0000);
                chk($sformatf("sp%0d_gap%0d_hold", s, g), dout[15:0], t2_exp[s]);
            end
        end

        // Mid-run reset with a commit pending
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 16'h00AA);
        tick();
        chk("pre_rst_busy", 16'(commit_busy), 16'h0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_dout0", dout[15:0], 16'h0000);
        chk("mid_rst_dout1", dout[31:16], 16'h0000);
        chk("mid_rst_primed", 16'(primed), 16'h0000);
        chk("mid_rst_busy", 16'(commit_busy), 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
        tick();
        #2 rst = 1'b0;

        // First strobe after reset: taps back at 0; ch3 gets tap 31 on the same strobe
        drive(1'b1, 1'b0, 1'b1, 2'd3, 5'd31, 1'b1, 16'h0055);
        tick();
        chk("post_rst_dout0", dout[15:0], 16'h0055);
        chk("post_rst_dout1", dout[31:16], 16'h1055);
        chk("post_rst_dout3", dout[63:48], 16'h0000);
        chk("post_rst_primed", 16'(primed), 16'b0111);

        // Maximum tap: primed after DEPTH strobes and stays primed once fill saturates
        for (int i = 2; i <= 40; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'(i));
            tick();
            if (i == 31) begin
                chk("max_tap_s31_primed3", 16'(primed[3]), 16'h0000);
                chk("max_tap_s31_dout3", dout[63:48], 16'h0000);
            end
            if (i == 32) begin
                chk("max_tap_s32_primed3", 16'(primed[3]), 16'h0001);
                chk("max_tap_s32_dout3", dout[63:48], 16'h3055);
            end
            if (i == 40) begin
                chk("max_tap_s40_primed3", 16'(primed[3]), 16'h0001);
                chk("max_tap_s40_dout3", dout[63:48], 16'h3009);
            end
        end

`ifdef DLY_INVERT_EN
        // Saturating negation on bypass data, ch0 inverted only
        invert = 4'b0001;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 16'h8000);
        tick();
        chk("inv_dout0", dout[15:0], 16'h7FFF);
        chk("inv_dout1", dout[31:16], 16'h9000);
        invert = 4'b0000;
`endif

        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
